// File: rtl/shift_operand_unit.sv
// Multi-cycle ARM operand-2 shifter: one shift/rotate step per clock, result latched on completion.
// Define SHIFT_OPERAND_RRX_EN to treat mode 01 ROR #0 as RRX instead of a no-shift pass-through.
module shift_operand_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [1:0]  shiftType,
    input  logic [31:0] value,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rotImm,
    input  logic [4:0]  shiftImm,
    input  logic [7:0]  shiftReg,
    input  logic        carryIn,
    output logic [31:0] out,
    output logic        carryOut,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;
    localparam logic [1:0] ShRor = 2'b11;

    typedef enum logic [1:0] {StIdle, StShift, StDone} shifterState;

    shifterState stateQ;
    logic [31:0] dataQ;
    logic        carryQ;
    logic [1:0]  typeQ;
    logic        rrxQ;
    logic [5:0]  countQ;
    logic [31:0] outQ;
    logic        carryOutQ;
    logic        busyQ;
    logic        doneQ;

    logic [31:0] loadData;
    logic [1:0]  loadType;
    logic [7:0]  amount;
    logic        loadRrx;
    logic [5:0]  loadCount;
    logic [31:0] stepData;
    logic        stepCarry;

    // Decode the operand fields into a working value, shift kind and step count.
    always_comb begin
        loadData  = value;
        loadType  = shiftType;
        amount    = 8'd0;
        loadRrx   = 1'b0;
        loadCount = 6'd0;
        unique case (mode)
            2'b00: begin
                loadData = {24'd0, imm8};
                loadType = ShRor;
                amount   = {3'd0, rotImm, 1'b0};
            end
            2'b10: amount = shiftReg;
            default: begin
                amount = {3'd0, shiftImm};
                if (shiftImm == 5'd0 && (shiftType == ShLsr || shiftType == ShAsr)) begin
                    amount = 8'd32;
                end
`ifdef SHIFT_OPERAND_RRX_EN
                if (shiftImm == 5'd0 && shiftType == ShRor) begin
                    loadRrx = 1'b1;
                end
`endif
            end
        endcase
        if (loadRrx) begin
            loadCount = 6'd1;
        end else begin
            unique case (loadType)
                ShLsl, ShLsr: loadCount = (amount > 8'd33) ? 6'd33 : amount[5:0];
                ShAsr:        loadCount = (amount > 8'd32) ? 6'd32 : amount[5:0];
                default: begin
                    if (amount == 8'd0) begin
                        loadCount = 6'd0;
                    end else if (amount[4:0] == 5'd0) begin
                        loadCount = 6'd32;
                    end else begin
                        loadCount = {1'b0, amount[4:0]};
                    end
                end
            endcase
        end
    end

    // Single-bit step; RRX pulls the working carry into bit 31.
    always_comb begin
        stepData  = dataQ;
        stepCarry = carryQ;
        if (rrxQ) begin
            stepData  = {carryQ, dataQ[31:1]};
            stepCarry = dataQ[0];
        end else begin
            unique case (typeQ)
                ShLsl: begin
                    stepData  = {dataQ[30:0], 1'b0};
                    stepCarry = dataQ[31];
                end
                ShLsr: begin
                    stepData  = {1'b0, dataQ[31:1]};
                    stepCarry = dataQ[0];
                end
                ShAsr: begin
                    stepData  = {dataQ[31], dataQ[31:1]};
                    stepCarry = dataQ[0];
                end
                default: begin
                    stepData  = {dataQ[0], dataQ[31:1]};
                    stepCarry = dataQ[0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= StIdle;
            dataQ     <= 32'd0;
            carryQ    <= 1'b0;
            typeQ     <= ShLsl;
            rrxQ      <= 1'b0;
            countQ    <= 6'd0;
            outQ      <= 32'd0;
            carryOutQ <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (start) begin
                        dataQ  <= loadData;
                        carryQ <= carryIn;
                        typeQ  <= loadType;
                        rrxQ   <= loadRrx;
                        countQ <= loadCount;
                        busyQ  <= 1'b1;
                        if (loadCount == 6'd0) begin
                            outQ      <= loadData;
                            carryOutQ <= carryIn;
                            doneQ     <= 1'b1;
                            stateQ    <= StDone;
                        end else begin
                            stateQ <= StShift;
                        end
                    end
                end
                StShift: begin
                    dataQ  <= stepData;
                    carryQ <= stepCarry;
                    countQ <= countQ - 6'd1;
                    // Final step goes straight to the output so latency stays N+1.
                    if (countQ == 6'd1) begin
                        outQ      <= stepData;
                        carryOutQ <= stepCarry;
                        doneQ     <= 1'b1;
                        stateQ    <= StDone;
                    end
                end
                StDone: begin
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b0;
                    stateQ <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign out      = outQ;
    assign carryOut = carryOutQ;
    assign busy     = busyQ;
    assign done     = doneQ;
endmodule

// File: tb/tb_shift_operand_unit.sv
// Self-checking bench for shift_operand_unit: arithmetic reference model plus per-cycle compare.
// Honours SHIFT_OPERAND_RRX_EN the same way as the design.
module tb_shift_operand_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  shiftType;
    logic [31:0] value;
    logic [7:0]  imm8;
    logic [3:0]  rotImm;
    logic [4:0]  shiftImm;
    logic [7:0]  shiftReg;
    logic        carryIn;
    logic [31:0] out;
    logic        carryOut;
    logic        busy;
    logic        done;

`ifdef SHIFT_OPERAND_RRX_EN
    localparam bit RrxOn = 1'b1;
`else
    localparam bit RrxOn = 1'b0;
`endif

    shift_operand_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .shiftType(shiftType),
        .value    (value),
        .imm8     (imm8),
        .rotImm   (rotImm),
        .shiftImm (shiftImm),
        .shiftReg (shiftReg),
        .carryIn  (carryIn),
        .out      (out),
        .carryOut (carryOut),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int          cmpCount = 0;
    int          errCount = 0;
    bit          checkOn = 1'b0;
    bit          active = 1'b0;
    int          edges = 0;
    int          pendN = 0;
    logic [31:0] pendOut = 32'd0;
    logic        pendCarry = 1'b0;
    logic [31:0] heldOut = 32'd0;
    logic        heldCarry = 1'b0;
    int          lastLat = 0;
    logic        expBusy;
    logic        expDone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-operation arithmetic on the architectural shift amount.
    function automatic void model(input logic [1:0] m, input logic [1:0] t, input logic [31:0] v,
                                  input logic [7:0] i8, input logic [3:0] rot, input logic [4:0] si,
                                  input logic [7:0] sr, input logic ci, output logic [31:0] o,
                                  output logic c, output int n);
        int          amt;
        int          r;
        logic [1:0]  ty;
        logic [31:0] d;
        d = v;
        ty = t;
        c = ci;
        o = v;
        if (m == 2'b00) begin
            d = {24'd0, i8};
            ty = 2'b11;
            amt = 2 * int'(rot);
        end else if (m == 2'b10) begin
            amt = int'(sr);
        end else begin
            amt = int'(si);
            if (si == 0 && (t == 2'b01 || t == 2'b10)) amt = 32;
            if (si == 0 && t == 2'b11 && RrxOn) begin
                n = 1;
                o = {ci, v[31:1]};
                c = v[0];
                return;
            end
        end
        o = d;
        case (ty)
            2'b00: begin
                n = (amt > 33) ? 33 : amt;
                if (amt > 0 && amt < 32) begin o = d << amt; c = d[32 - amt]; end
                else if (amt == 32) begin o = 0; c = d[0]; end
                else if (amt > 32) begin o = 0; c = 1'b0; end
            end
            2'b01: begin
                n = (amt > 33) ? 33 : amt;
                if (amt > 0 && amt < 32) begin o = d >> amt; c = d[amt - 1]; end
                else if (amt == 32) begin o = 0; c = d[31]; end
                else if (amt > 32) begin o = 0; c = 1'b0; end
            end
            2'b10: begin
                n = (amt > 32) ? 32 : amt;
                if (amt > 0 && amt < 32) begin o = $signed(d) >>> amt; c = d[amt - 1]; end
                else if (amt >= 32) begin o = {32{d[31]}}; c = d[31]; end
            end
            default: begin
                n = (amt == 0) ? 0 : ((amt - 1) % 32) + 1;
                if (amt != 0) begin
                    r = amt % 32;
                    if (r == 0) c = d[31];
                    else begin o = (d >> r) | (d << (32 - r)); c = d[r - 1]; end
                end
            end
        endcase
    endfunction

    // Compare process: busy/done/out/carryOut every cycle, #1 after the active edge.
    always @(posedge clk) begin
        #1;
        if (reset_n && checkOn) begin
            expBusy = active;
            expDone = 1'b0;
            if (active) begin
                edges++;
                if (edges == pendN + 1) begin
                    expDone = 1'b1;
                    heldOut = pendOut;
                    heldCarry = pendCarry;
                    lastLat = edges;
                    active = 1'b0;
                end
            end
            chk("busy", {31'd0, busy}, {31'd0, expBusy});
            chk("done", {31'd0, done}, {31'd0, expDone});
            chk("out", out, heldOut);
            chk("carryOut", {31'd0, carryOut}, {31'd0, heldCarry});
        end
    end

    task automatic issue(input logic [1:0] m, input logic [1:0] t, input logic [31:0] v,
                         input logic [7:0] i8, input logic [3:0] rot, input logic [4:0] si,
                         input logic [7:0] sr, input logic ci);
        @(negedge clk);
        mode = m; shiftType = t; value = v; imm8 = i8;
        rotImm = rot; shiftImm = si; shiftReg = sr; carryIn = ci;
        model(m, t, v, i8, rot, si, sr, ci, pendOut, pendCarry, pendN);
        edges = 0;
        active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitOp();
        int k = 0;
        while (active && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (active) begin
            cmpCount++;
            errCount++;
            $display("FAIL timeout: done not seen within %0d cycles", k);
            active = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic runOp(input logic [1:0] m, input logic [1:0] t, input logic [31:0] v,
                         input logic [7:0] i8, input logic [3:0] rot, input logic [4:0] si,
                         input logic [7:0] sr, input logic ci);
        issue(m, t, v, i8, rot, si, sr, ci);
        waitOp();
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        mode = 2'b00; shiftType = 2'b00; value = 32'd0; imm8 = 8'd0;
        rotImm = 4'd0; shiftImm = 5'd0; shiftReg = 8'd0; carryIn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        checkOn = 1'b1;

        runOp(2'b00, 2'b00, 32'h0, 8'hFF, 4'd4, 5'd0, 8'd0, 1'b0);
        chk("imm_rot_out", out, 32'hFF000000);
        chk("imm_rot_c", {31'd0, carryOut}, 32'd1);
        chk("imm_rot_lat", lastLat, 32'd9);

        runOp(2'b10, 2'b00, 32'hFFFFFFFF, 8'd0, 4'd0, 5'd0, 8'd33, 1'b1);
        chk("lsl33_out", out, 32'd0);
        chk("lsl33_c", {31'd0, carryOut}, 32'd0);
        chk("lsl33_lat", lastLat, 32'd34);

        runOp(2'b10, 2'b00, 32'hFFFFFFFF, 8'd0, 4'd0, 5'd0, 8'd32, 1'b0);
        chk("lsl32_c", {31'd0, carryOut}, 32'd1);

        runOp(2'b01, 2'b01, 32'h80000000, 8'd0, 4'd0, 5'd0, 8'd0, 1'b0);
        chk("lsr0_c", {31'd0, carryOut}, 32'd1);
        chk("lsr0_lat", lastLat, 32'd33);

        runOp(2'b10, 2'b10, 32'h80000000, 8'd0, 4'd0, 5'd0, 8'd200, 1'b0);
        chk("asr200_out", out, 32'hFFFFFFFF);

        runOp(2'b01, 2'b11, 32'h00000001, 8'd0, 4'd0, 5'd0, 8'd0, 1'b1);
        chk("ror0_out", out, RrxOn ? 32'h80000000 : 32'h00000001);
        chk("ror0_lat", lastLat, RrxOn ? 32'd2 : 32'd1);

        runOp(2'b10, 2'b11, 32'h12345678, 8'd0, 4'd0, 5'd0, 8'd32, 1'b1);
        chk("ror32_out", out, 32'h12345678);
        chk("ror32_c", {31'd0, carryOut}, 32'd0);

        runOp(2'b10, 2'b11, 32'h12345678, 8'd0, 4'd0, 5'd0, 8'd0, 1'b1);
        chk("rorreg0_c", {31'd0, carryOut}, 32'd1);
        chk("rorreg0_lat", lastLat, 32'd1);

        runOp(2'b01, 2'b00, 32'h0000000F, 8'd0, 4'd0, 5'd4, 8'd0, 1'b1);
        chk("lsl4_out", out, 32'h000000F0);
        runOp(2'b11, 2'b10, 32'hF0000001, 8'd0, 4'd0, 5'd1, 8'd0, 1'b0);
        runOp(2'b10, 2'b11, 32'h000000F1, 8'd0, 4'd0, 5'd0, 8'd36, 1'b0);
        runOp(2'b10, 2'b01, 32'hA5A5A5A5, 8'd0, 4'd0, 5'd0, 8'd7, 1'b0);
        runOp(2'b00, 2'b01, 32'h0, 8'h81, 4'd1, 5'd0, 8'd0, 1'b0);

        // Start pulse while shifting must not reload the operation.
        issue(2'b10, 2'b01, 32'hDEADBEEF, 8'd0, 4'd0, 5'd0, 8'd20, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; mode = 2'b00; imm8 = 8'h3C; rotImm = 4'd2; value = 32'h0;
        @(negedge clk);
        start = 1'b0;
        waitOp();
        chk("ignored_start_out", out, 32'h00000DEA);

        // Asynchronous reset in the middle of a 20-step shift.
        issue(2'b10, 2'b00, 32'hFFFFFFFF, 8'd0, 4'd0, 5'd0, 8'd20, 1'b1);
        repeat (8) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_out", out, 32'd0);
        chk("midreset_c", {31'd0, carryOut}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        active = 1'b0;
        heldOut = 32'd0;
        heldCarry = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        runOp(2'b10, 2'b10, 32'h80000010, 8'd0, 4'd0, 5'd0, 8'd4, 1'b0);
        chk("post_reset_out", out, 32'hF8000001);
        chk("post_reset_lat", lastLat, 32'd5);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
